// File: rtl/div_job_sequencer.sv
// Operand FIFO and job sequencer in front of the 10-bit sequential divider.
// Issues one (A, B) job at a time and holds each result (or timeout) in an output slot.
module div_job_sequencer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 32,
  localparam int unsigned DW     = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_A,
  input  logic [DW-1:0] in_B,
  output logic          div_start,
  output logic [DW-1:0] div_A,
  output logic [DW-1:0] div_B,
  input  logic          div_done,
  input  logic [DW-1:0] div_q,
  input  logic          div_dvz,
  input  logic          div_ovf,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_q,
  output logic          res_dvz,
  output logic          res_ovf,
  output logic          res_tmo,
  output logic          busy
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  state_t        state;
  op_t           mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [TW-1:0] wait_cnt;
  logic          push;
  logic          pop;
  logic          slot_free;
  logic          timeout_hit;

  assign in_ready    = (count != CW'(DEPTH));
  assign push        = in_valid && in_ready;
  assign pop         = (state == S_ISSUE);
  assign div_start   = (state == S_ISSUE);
  assign busy        = (state != S_IDLE) || (count != '0);
  assign slot_free   = !res_valid || res_ready;
  assign timeout_hit = (wait_cnt == TW'(TIMEOUT - 1));

  // Operand storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {in_A, in_B};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      wait_cnt  <= '0;
      div_A     <= '0;
      div_B     <= '0;
      res_valid <= 1'b0;
      res_q     <= '0;
      res_dvz   <= 1'b0;
      res_ovf   <= 1'b0;
      res_tmo   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      // Consumer drain; a capture below in the same cycle overrides it.
      if (res_valid && res_ready) begin
        res_valid <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if ((count != '0) && slot_free) begin
            div_A <= mem[rd_ptr].a;
            div_B <= mem[rd_ptr].b;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + TW'(1);
          if (div_done) begin
            res_q     <= div_q;
            res_dvz   <= div_dvz;
            res_ovf   <= div_ovf;
            res_tmo   <= 1'b0;
            res_valid <= 1'b1;
            state     <= S_IDLE;
          end else if (timeout_hit) begin
            res_q     <= '0;
            res_dvz   <= 1'b0;
            res_ovf   <= 1'b0;
            res_tmo   <= 1'b1;
            res_valid <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_job_sequencer.sv
// Randomized bench for div_job_sequencer: a transaction-level model of the job
// queue, divider responses and the result slot predicts every output each cycle.
module tb_div_job_sequencer;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 32;
  localparam int          NEVER   = -1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_A;
  logic [9:0] in_B;
  logic       div_start;
  logic [9:0] div_A;
  logic [9:0] div_B;
  logic       div_done;
  logic [9:0] div_q;
  logic       div_dvz;
  logic       div_ovf;
  logic       res_valid;
  logic       res_ready;
  logic [9:0] res_q;
  logic       res_dvz;
  logic       res_ovf;
  logic       res_tmo;
  logic       busy;

  div_job_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
    .div_start(div_start), .div_A(div_A), .div_B(div_B),
    .div_done(div_done), .div_q(div_q), .div_dvz(div_dvz), .div_ovf(div_ovf),
    .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q),
    .res_dvz(res_dvz), .res_ovf(res_ovf), .res_tmo(res_tmo), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] a;
    logic [9:0] b;
  } op_t;

  typedef struct packed {
    logic [9:0] q;
    logic       dvz;
    logic       ovf;
    logic       tmo;
  } res_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  op_t  gen_q[$];
  op_t  fifo_m[$];
  op_t  cur_op;
  res_t job_res;
  res_t done_res;
  res_t slot_val;
  res_t last_res;
  bit   slot_valid = 0;
  bit   job_active = 0;
  int   exp_start = -1;
  int   done_cyc = -1;
  int   cap_cyc = -1;
  int   lat_fix = 12;
  bit   lat_rand = 0;
  int   push_pct = 100;
  int   ready_pct = 100;
  bit   rnd_ovf = 0;
  int   last_push_cyc = -1;
  int   last_start_cyc = -1;
  int   n_starts = 0;
  int   n_consumed = 0;
  int   n_full_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic op_t mk_op(input int a, input int b);
    op_t o;
    o.a = 10'(a);
    o.b = 10'(b);
    return o;
  endfunction

  // Behaviour of the divider itself: quotient, divide-by-zero flag, optional overflow flag.
  function automatic res_t div_model(input op_t op, input logic ovf_bit);
    res_t r;
    r.tmo = 1'b0;
    if (op.b == 10'd0) begin
      r.q   = 10'd0;
      r.dvz = 1'b1;
      r.ovf = 1'b0;
    end else begin
      r.q   = op.a / op.b;
      r.dvz = 1'b0;
      r.ovf = ovf_bit;
    end
    return r;
  endfunction

  function automatic int pick_lat();
    int p;
    if (!lat_rand) return lat_fix;
    p = int'($urandom_range(99));
    if (p < 8)  return NEVER;
    if (p < 20) return 30 + int'($urandom_range(5));
    return 1 + int'($urandom_range(19));
  endfunction

  // One clock cycle: check outputs, drive inputs, then advance the model past the next edge.
  task automatic tick();
    int   pre_size;
    int   lat;
    bit   exp_busy;
    res_t r;
    res_t tmo_res;
    @(negedge clk);
    cyc++;
    pre_size = fifo_m.size();
    exp_busy = (pre_size > 0) || job_active || (cyc == exp_start);
    check("div_start", 32'(div_start), 32'(cyc == exp_start));
    check("in_ready", 32'(in_ready), 32'(pre_size < int'(DEPTH)));
    check("busy", 32'(busy), 32'(exp_busy));
    check("res_valid", 32'(res_valid), 32'(slot_valid));
    if (slot_valid) begin
      check("res_q", 32'(res_q), 32'(slot_val.q));
      check("res_dvz", 32'(res_dvz), 32'(slot_val.dvz));
      check("res_ovf", 32'(res_ovf), 32'(slot_val.ovf));
      check("res_tmo", 32'(res_tmo), 32'(slot_val.tmo));
    end
    if (div_start) n_starts++;
    if (!in_ready) n_full_cyc++;

    if (cyc == exp_start) begin
      cur_op   = fifo_m.pop_front();
      lat      = pick_lat();
      r        = div_model(cur_op, rnd_ovf ? 1'($urandom) : 1'b0);
      done_res = r;
      done_cyc = (lat < 0) ? -1 : cyc + lat;
      if (done_cyc >= 0 && done_cyc <= cyc + int'(TIMEOUT)) begin
        cap_cyc = done_cyc;
        job_res = r;
      end else begin
        tmo_res.q   = 10'd0;
        tmo_res.dvz = 1'b0;
        tmo_res.ovf = 1'b0;
        tmo_res.tmo = 1'b1;
        cap_cyc = cyc + int'(TIMEOUT);
        job_res = tmo_res;
      end
      job_active     = 1;
      exp_start      = -1;
      last_start_cyc = cyc;
    end
    if (job_active) begin
      check("div_A", 32'(div_A), 32'(cur_op.a));
      check("div_B", 32'(div_B), 32'(cur_op.b));
    end

    div_done = (cyc == done_cyc);
    if (div_done) begin
      div_q   = done_res.q;
      div_dvz = done_res.dvz;
      div_ovf = done_res.ovf;
    end else begin
      div_q   = 10'($urandom);
      div_dvz = 1'($urandom);
      div_ovf = 1'($urandom);
    end
    if (gen_q.size() > 0 && int'($urandom_range(99)) < push_pct) begin
      in_valid = 1'b1;
      in_A     = gen_q[0].a;
      in_B     = gen_q[0].b;
    end else begin
      in_valid = 1'b0;
      in_A     = 10'($urandom);
      in_B     = 10'($urandom);
    end
    res_ready = (int'($urandom_range(99)) < ready_pct);

    // A queued job is launched only from idle and only when the result slot can take it.
    if (!job_active && exp_start < 0 && pre_size > 0 && (!slot_valid || res_ready))
      exp_start = cyc + 1;
    if (in_valid && pre_size < int'(DEPTH)) begin
      fifo_m.push_back(gen_q.pop_front());
      last_push_cyc = cyc;
    end
    if (slot_valid && res_ready) begin
      slot_valid = 0;
      last_res   = slot_val;
      n_consumed++;
    end
    if (cyc == cap_cyc) begin
      slot_valid = 1;
      slot_val   = job_res;
      job_active = 0;
      cap_cyc    = -1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic drain(input string tag, input int max);
    int k = 0;
    while ((gen_q.size() > 0 || fifo_m.size() > 0 || job_active || exp_start >= 0 || slot_valid)
           && k < max) begin
      tick();
      k++;
    end
    check(tag, 32'(k < max), 32'd1);
  endtask

  task automatic async_reset_check();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_res_valid", 32'(res_valid), 32'd0);
    check("rst_div_A", 32'(div_A), 32'd0);
    check("rst_div_B", 32'(div_B), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_div_start", 32'(div_start), 32'd0);
    in_valid  = 1'b0;
    div_done  = 1'b0;
    res_ready = 1'b0;
    fifo_m.delete();
    gen_q.delete();
    slot_valid = 0;
    job_active = 0;
    exp_start  = -1;
    done_cyc   = -1;
    cap_cyc    = -1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    int c0;
    bit found;
    rst_n = 1'b0; in_valid = 1'b0; in_A = '0; in_B = '0;
    div_done = 1'b0; div_q = '0; div_dvz = 1'b0; div_ovf = 1'b0; res_ready = 1'b0;
    #12;
    check("reset_state", 32'({res_valid, res_dvz, res_ovf, res_tmo, div_start, busy}), 32'd0);
    check("reset_res_q", 32'(res_q), 32'd0);
    check("reset_div_AB", 32'({div_A, div_B}), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Single job into an empty, idle block.
    lat_fix = 12;
    gen_q.push_back(mk_op(100, 7));
    drain("single_drain", 100);
    check("single_latency", 32'(last_start_cyc - last_push_cyc), 32'd2);
    check("single_q", 32'(last_res.q), 32'h00E);
    check("single_flags", 32'({last_res.dvz, last_res.ovf, last_res.tmo}), 32'd0);

    // Divide by zero.
    lat_fix = 9;
    gen_q.push_back(mk_op(5, 0));
    drain("dvz_drain", 100);
    check("dvz_flags", 32'({last_res.dvz, last_res.ovf, last_res.tmo}), 32'b100);
    check("dvz_q", 32'(last_res.q), 32'd0);

    // FIFO fills while the divider never answers; every job times out.
    lat_fix = NEVER;
    for (int i = 0; i < 6; i++) gen_q.push_back(mk_op(i + 1, 1));
    n_full_cyc = 0;
    drain("full_drain", 400);
    check("full_seen", 32'(n_full_cyc > 0), 32'd1);

    // Done on the last allowed wait cycle wins; one cycle later is a timeout.
    lat_fix = 32;
    gen_q.push_back(mk_op(600, 3));
    drain("lat32_drain", 100);
    check("lat32_q", 32'(last_res.q), 32'd200);
    check("lat32_tmo", 32'(last_res.tmo), 32'd0);
    lat_fix = 33;
    gen_q.push_back(mk_op(600, 3));
    drain("lat33_drain", 100);
    check("lat33_tmo", 32'(last_res.tmo), 32'd1);
    check("lat33_q", 32'(last_res.q), 32'd0);

    // Timeout held in the slot while a late done arrives.
    lat_fix   = 36;
    ready_pct = 0;
    gen_q.push_back(mk_op(77, 7));
    c0 = n_consumed;
    run(60);
    check("late_done_held", 32'(n_consumed - c0), 32'd0);
    ready_pct = 100;
    drain("late_drain", 100);
    check("late_tmo", 32'({last_res.q, last_res.tmo}), 32'd1);

    // Backpressure on the result slot blocks the next issue.
    lat_fix   = 5;
    ready_pct = 0;
    gen_q.push_back(mk_op(50, 5));
    gen_q.push_back(mk_op(90, 9));
    s0 = n_starts;
    run(40);
    check("bp_blocked_starts", 32'(n_starts - s0), 32'd1);
    ready_pct = 100;
    drain("bp_drain", 100);
    check("bp_total_starts", 32'(n_starts - s0), 32'd2);

    // Randomized traffic.
    lat_rand  = 1;
    rnd_ovf   = 1;
    push_pct  = 60;
    ready_pct = 70;
    for (int i = 0; i < 120; i++)
      gen_q.push_back(mk_op(int'($urandom_range(1023)),
                            ($urandom_range(9) == 0) ? 0 : int'($urandom_range(1023))));
    drain("rand_drain", 8000);

    // Asynchronous reset while a job waits and two more are queued.
    lat_rand  = 0;
    rnd_ovf   = 0;
    lat_fix   = NEVER;
    push_pct  = 100;
    ready_pct = 100;
    gen_q.push_back(mk_op(300, 3));
    gen_q.push_back(mk_op(400, 4));
    gen_q.push_back(mk_op(500, 5));
    found = 0;
    for (int k = 0; k < 60 && !found; k++) begin
      tick();
      if (job_active && fifo_m.size() == 2 && cyc > last_start_cyc + 2) found = 1;
    end
    check("rst_setup_found", 32'(found), 32'd1);
    async_reset_check();
    s0 = n_starts;
    run(10);
    check("post_rst_no_start", 32'(n_starts - s0), 32'd0);
    lat_fix = 3;
    gen_q.push_back(mk_op(21, 4));
    drain("post_rst_drain", 100);
    check("post_rst_q", 32'(last_res.q), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
